pc_unit: RTL and testbench

- Parametrised next-generation program counter for the RISC-V datapath.
- Holds the fetch address and computes the next PC for sequential flow, conditional branches, JAL and JALR.
- Detects misaligned control-flow targets and redirects to a trap vector; saves the faulting PC and supports trap return.
- Sits between the fetch path (drives `addr`) and the decode/ALU stage, which supplies opcode, func, immediate, rs1 and comparator flags.

---
 rtl/pc_unit.sv | 128 ++++++++++++
 tb/tb_pc_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter with branch/JAL/JALR target selection, misaligned-target trap and trap return.
// Define PC_UNIT_C_EXT_EN for 16-bit instruction support (2-byte increment, no misaligned trap).
module pc_unit #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            LOAD,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func,
    input  logic            EQ,
    input  logic            LT_SN,
    input  logic            LT_UN,
    input  logic            GT_SN,
    input  logic            GT_UN,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] rs1,
    input  logic            trap_ret,
    input  logic            insn_c,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] link,
    output logic [XLEN-1:0] epc,
    output logic            taken,
    output logic            in_trap,
    output logic            double_fault
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_TRAP = 1'b1;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [0:0]      state;
    logic            br_cond;
    logic            misaligned;
    logic [XLEN-1:0] ilen;
    logic [XLEN-1:0] ret_len;
    logic [XLEN-1:0] seq;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;

`ifdef PC_UNIT_C_EXT_EN
    logic epc_c;

    assign ilen       = insn_c ? XLEN'(2) : XLEN'(4);
    assign ret_len    = epc_c ? XLEN'(2) : XLEN'(4);
    // Only bit 0 must be clear with compressed code, and JALR already forces it.
    assign misaligned = 1'b0;

    always_ff @(negedge CLK or negedge RST) begin
        if (!RST)
            epc_c <= 1'b0;
        else if (LOAD && misaligned && state == S_RUN && !trap_ret)
            epc_c <= insn_c;
    end
`else
    logic unused_insn_c;

    assign unused_insn_c = insn_c;
    assign ilen          = XLEN'(4);
    assign ret_len       = XLEN'(4);
    assign misaligned    = taken & target[1];
`endif

    always_comb begin
        br_cond = 1'b0;
        case (func)
            3'b000:  br_cond = EQ;
            3'b001:  br_cond = ~EQ;
            3'b100:  br_cond = LT_SN;
            3'b101:  br_cond = GT_SN;
            3'b110:  br_cond = LT_UN;
            3'b111:  br_cond = GT_UN;
            default: br_cond = 1'b0;
        endcase
    end

    assign seq      = addr + ilen;
    assign jalr_sum = rs1 + immediate;
    assign link     = seq;

    always_comb begin
        target = seq;
        taken  = 1'b0;
        if (opcode == OP_JAL) begin
            target = addr + immediate;
            taken  = 1'b1;
        end else if (opcode == OP_JALR) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
            taken  = 1'b1;
        end else if (opcode == OP_BRANCH && br_cond) begin
            target = addr + immediate;
            taken  = 1'b1;
        end
    end

    // Trap return outranks any redirect; a fault inside TRAP keeps the original epc.
    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            addr         <= RESET_VECTOR;
            epc          <= '0;
            state        <= S_RUN;
            double_fault <= 1'b0;
        end else if (LOAD) begin
            if (state == S_TRAP && trap_ret) begin
                addr  <= epc + ret_len;
                state <= S_RUN;
            end else if (misaligned) begin
                addr <= TRAP_VECTOR;
                if (state == S_RUN) begin
                    epc   <= addr;
                    state <= S_TRAP;
                end else begin
                    double_fault <= 1'b1;
                end
            end else begin
                addr <= target;
            end
        end
    end

    assign in_trap = (state == S_TRAP);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit (XLEN=32): expectations queued at drive time, popped at sample time.
module tb_pc_unit;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            LOAD = 1'b0;
    logic [6:0]      opcode = OP_IMM;
    logic [2:0]      func = 3'b000;
    logic            EQ = 1'b0, LT_SN = 1'b0, LT_UN = 1'b0, GT_SN = 1'b0, GT_UN = 1'b0;
    logic [XLEN-1:0] immediate = '0;
    logic [XLEN-1:0] rs1 = '0;
    logic            trap_ret = 1'b0;
    logic            insn_c = 1'b0;
    logic [XLEN-1:0] addr, link, epc;
    logic            taken, in_trap, double_fault;

    pc_unit #(.XLEN(XLEN), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100)) dut (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .opcode(opcode), .func(func),
        .EQ(EQ), .LT_SN(LT_SN), .LT_UN(LT_UN), .GT_SN(GT_SN), .GT_UN(GT_UN),
        .immediate(immediate), .rs1(rs1), .trap_ret(trap_ret), .insn_c(insn_c),
        .addr(addr), .link(link), .epc(epc), .taken(taken), .in_trap(in_trap),
        .double_fault(double_fault)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty got=%h expected=<queued value>", obs);
        end else begin
            e = exp_q.pop_front();
            n_tests++;
            assert (obs === e.v) else begin
                n_fail++;
                $error("FAIL %s got=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    // One falling edge (state update), then back to the rising edge where inputs change.
    task automatic tick();
        @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f, input logic [31:0] imm);
        opcode    = op;
        func      = f;
        immediate = imm;
        #1;
    endtask

    initial begin
        logic [7:0] flags;
        logic       exp_t_b;

        // Reset held for two cycles
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        expect_v("rst_addr", 32'h0);         cmp(addr);
        expect_v("rst_in_trap", 32'h0);      cmp({31'b0, in_trap});
        expect_v("rst_epc", 32'h0);          cmp(epc);
        expect_v("rst_double_fault", 32'h0); cmp({31'b0, double_fault});
        RST  = 1'b1;
        LOAD = 1'b1;

        drive(OP_IMM, 3'b000, 32'h0);
        expect_v("seq_link", 32'h4); cmp(link);
        expect_v("seq_taken", 32'h0); cmp({31'b0, taken});
        repeat (4) tick();
        expect_v("seq_x4_addr", 32'h10); cmp(addr);

        // JAL 0x10 -> 0x20
        drive(OP_JAL, 3'b000, 32'h10);
        expect_v("jal_taken", 32'h1); cmp({31'b0, taken});
        tick();
        expect_v("jal_addr", 32'h20); cmp(addr);

        // BNE not equal, imm -8
        EQ = 1'b0;
        drive(OP_BR, 3'b001, 32'hFFFF_FFF8);
        expect_v("bne_taken", 32'h1); cmp({31'b0, taken});
        tick();
        expect_v("bne_addr", 32'h18); cmp(addr);

        drive(OP_IMM, 3'b000, 32'h0);
        repeat (2) tick();
        expect_v("back_to_20", 32'h20); cmp(addr);
        EQ = 1'b1;
        drive(OP_BR, 3'b001, 32'hFFFF_FFF8);
        expect_v("bne_eq_taken", 32'h0); cmp({31'b0, taken});
        tick();
        expect_v("bne_eq_addr", 32'h24); cmp(addr);
        EQ = 1'b0;

        // Reach 0x40, then misaligned JALR
        drive(OP_JAL, 3'b000, 32'h1C);
        tick();
        expect_v("jal_to_40", 32'h40); cmp(addr);
        rs1 = 32'h1003;
        drive(OP_JR, 3'b000, 32'h4);
        expect_v("jalr_link", 32'h44); cmp(link);
        tick();
        expect_v("jalr_trap_addr", 32'h100); cmp(addr);
        expect_v("jalr_trap_epc", 32'h40);   cmp(epc);
        expect_v("jalr_in_trap", 32'h1);     cmp({31'b0, in_trap});
        expect_v("no_double_yet", 32'h0);    cmp({31'b0, double_fault});

        // Misaligned JAL inside TRAP
        drive(OP_JAL, 3'b000, 32'h2);
        tick();
        expect_v("dbl_flag", 32'h1);     cmp({31'b0, double_fault});
        expect_v("dbl_addr", 32'h100);   cmp(addr);
        expect_v("dbl_epc", 32'h40);     cmp(epc);
        expect_v("dbl_in_trap", 32'h1);  cmp({31'b0, in_trap});

        // Trap return beats a simultaneous JAL
        trap_ret = 1'b1;
        drive(OP_JAL, 3'b000, 32'h8);
        tick();
        trap_ret = 1'b0;
        expect_v("tret_addr", 32'h44);   cmp(addr);
        expect_v("tret_in_trap", 32'h0); cmp({31'b0, in_trap});
        expect_v("dbl_sticky", 32'h1);   cmp({31'b0, double_fault});

        // Stall during a taken JAL
        LOAD = 1'b0;
        drive(OP_JAL, 3'b000, 32'h20);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_v("stall_addr", 32'h44); cmp(addr);
        end
        LOAD = 1'b1;
        tick();
        expect_v("stall_release", 32'h64); cmp(addr);

        // trap_ret ignored in RUN
        trap_ret = 1'b1;
        drive(OP_IMM, 3'b000, 32'h0);
        tick();
        trap_ret = 1'b0;
        expect_v("tret_in_run_addr", 32'h68); cmp(addr);
        expect_v("tret_in_run_state", 32'h0); cmp({31'b0, in_trap});

        // Branch condition sweep (stalled, combinational only)
        LOAD = 1'b0;
        for (int f = 0; f < 8; f++) begin
            for (int p = 0; p < 4; p++) begin
                flags = 8'($urandom_range(0, 31));
                {EQ, LT_SN, LT_UN, GT_SN, GT_UN} = flags[4:0];
                case (f)
                    0: exp_t_b = flags[4];
                    1: exp_t_b = ~flags[4];
                    4: exp_t_b = flags[3];
                    5: exp_t_b = flags[1];
                    6: exp_t_b = flags[2];
                    7: exp_t_b = flags[0];
                    default: exp_t_b = 1'b0;
                endcase
                drive(OP_BR, 3'(f), 32'h10);
                expect_v($sformatf("br_cond_f%0d", f), {31'b0, exp_t_b}); cmp({31'b0, taken});
            end
        end
        {EQ, LT_SN, LT_UN, GT_SN, GT_UN} = 5'b0;
        LOAD = 1'b1;

        // Second trap, sequential flow inside TRAP, then return
        rs1 = 32'h2;
        drive(OP_JR, 3'b000, 32'h0);
        tick();
        expect_v("trap2_epc", 32'h68);   cmp(epc);
        expect_v("trap2_addr", 32'h100); cmp(addr);
        drive(OP_IMM, 3'b000, 32'h0);
        tick();
        expect_v("trap_seq_addr", 32'h104); cmp(addr);
        expect_v("trap_seq_state", 32'h1);  cmp({31'b0, in_trap});
        trap_ret = 1'b1;
        tick();
        trap_ret = 1'b0;
        expect_v("tret2_addr", 32'h6C); cmp(addr);

        // Wrap-around
        rs1 = 32'hFFFF_FFF8;
        drive(OP_JR, 3'b000, 32'h4);
        tick();
        expect_v("wrap_setup", 32'hFFFF_FFFC); cmp(addr);
        drive(OP_IMM, 3'b000, 32'h0);
        expect_v("wrap_link", 32'h0); cmp(link);
        tick();
        expect_v("wrap_addr", 32'h0); cmp(addr);

        // Asynchronous reset mid-operation
        drive(OP_JAL, 3'b000, 32'h40);
        tick();
        RST = 1'b0;
        #1;
        expect_v("async_rst_addr", 32'h0); cmp(addr);
        expect_v("async_rst_dbl", 32'h0);  cmp({31'b0, double_fault});
        expect_v("async_rst_trap", 32'h0); cmp({31'b0, in_trap});

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
